// File: rtl/pkt_w16_pkg.sv
// Shared types and constants for the 16-bit word to 8-bit byte re-serialiser.
package pkt_w16_pkg;

    localparam int WORD_W         = 19;
    localparam int BYTES_PER_WORD = 2;

    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 15;
    localparam int MTY_BIT  = 16;
    localparam int EOP_BIT  = 17;
    localparam int SOP_BIT  = 18;

    // Field order matches the bit offsets above: sop is bit 18, data is 15:0.
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        mty;
        logic [15:0] data;
    } word_t;

    function automatic word_t make_word(input logic sop, input logic eop,
                                        input logic mty, input logic [15:0] data);
        word_t w;
        w.sop  = sop;
        w.eop  = eop;
        w.mty  = mty;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/pkt_word_buf.sv
// Small circular word FIFO; the head falls through from the write port when empty
// so a word pushed into an empty buffer can be consumed in the same cycle.
module pkt_word_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int W     = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          head_vld,
    output logic [AW:0]   count_next,
    output logic          full
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty, do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_FULL);
        // A push that is popped straight off an empty buffer never lands in memory.
        do_rd    = pop && !empty;
        do_wr    = push && !(empty && pop) && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_wr && !do_rd)      count_d = count_q + 1'b1;
        else if (!do_wr && do_rd) count_d = count_q - 1'b1;
        head       = empty ? push_data : mem_q[rd_ptr_q];
        head_vld   = !empty || push;
        count_next = count_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pkt_w16_to_b8.sv
// Re-serialises the packer's 16-bit sop/eop/mty word stream into an 8-bit byte
// stream, throttling the upstream through a registered b_rdy.
module pkt_w16_to_b8
    import pkt_w16_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int BUF_AW    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        din_mty,
    output logic        b_rdy,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    input  logic        out_rdy,
    output logic        ovf_err
);

    word_t             in_word, head_word;
    logic [WORD_W-1:0] buf_head;
    logic              head_vld, buf_full, pop, load;
    logic [BUF_AW:0]   count_next;

    logic [7:0] dout_q, dout_d;
    logic       dout_vld_q, dout_vld_d;
    logic       dout_sop_q, dout_sop_d;
    logic       dout_eop_q, dout_eop_d;
    logic       byte_sel_q, byte_sel_d;
    logic       b_rdy_q, b_rdy_d;
    logic       ovf_q, ovf_d;

    assign in_word = make_word(din_sop, din_eop, din_mty, din);

    pkt_word_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (BUF_AW),
        .W     (WORD_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (din_vld),
        .push_data  (in_word),
        .pop        (pop),
        .head       (buf_head),
        .head_vld   (head_vld),
        .count_next (count_next),
        .full       (buf_full)
    );

    always_comb begin
        head_word  = word_t'(buf_head);
        load       = (!dout_vld_q || out_rdy) && head_vld;
        pop        = 1'b0;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        dout_sop_d = dout_sop_q;
        dout_eop_d = dout_eop_q;
        byte_sel_d = byte_sel_q;
        if (load) begin
            dout_vld_d = 1'b1;
            if (!byte_sel_q && head_word.eop && head_word.mty) begin
                // Odd-length tail: only the upper byte exists.
                dout_d     = head_word.data[15:8];
                dout_sop_d = head_word.sop;
                dout_eop_d = 1'b1;
                pop        = 1'b1;
            end else if (!byte_sel_q) begin
                dout_d     = head_word.data[7:0];
                dout_sop_d = head_word.sop;
                dout_eop_d = 1'b0;
                byte_sel_d = 1'b1;
            end else begin
                dout_d     = head_word.data[15:8];
                dout_sop_d = 1'b0;
                dout_eop_d = head_word.eop;
                byte_sel_d = 1'b0;
                pop        = 1'b1;
            end
        end else if (out_rdy) begin
            dout_d     = '0;
            dout_vld_d = 1'b0;
            dout_sop_d = 1'b0;
            dout_eop_d = 1'b0;
        end
        ovf_d   = ovf_q || (din_vld && buf_full && !pop);
        b_rdy_d = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            byte_sel_q <= 1'b0;
            b_rdy_q    <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            byte_sel_q <= byte_sel_d;
            b_rdy_q    <= b_rdy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign b_rdy    = b_rdy_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_pkt_w16_to_b8.sv
// Directed bench for pkt_w16_to_b8: per-cycle input rows against hand-computed
// {ovf_err, b_rdy, dout_vld, dout_sop, dout_eop, dout} expectations.
module tb_pkt_w16_to_b8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_vld, din_sop, din_eop, din_mty;
    logic        b_rdy;
    logic [7:0]  dout;
    logic        dout_vld, dout_sop, dout_eop;
    logic        out_rdy;
    logic        ovf_err;

    int total = 0;
    int bad   = 0;

    pkt_w16_to_b8 #(.BUF_DEPTH(2), .BUF_AW(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .din_mty  (din_mty),
        .b_rdy    (b_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .out_rdy  (out_rdy),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    // Row: {rst_n, out_rdy, din_vld, sop, eop, mty, data[15:0]}
    function automatic logic [21:0] mk(input logic r, input logic o, input logic v,
                                       input logic s, input logic e, input logic m,
                                       input logic [15:0] d);
        return {r, o, v, s, e, m, d};
    endfunction

    // Expect: {ovf_err, b_rdy, dout_vld, dout_sop, dout_eop, dout[7:0]}
    function automatic logic [12:0] ex(input logic ov, input logic br, input logic v,
                                       input logic s, input logic e, input logic [7:0] d);
        return {ov, br, v, s, e, d};
    endfunction

    task automatic apply(input logic [21:0] r);
        rst_n   = r[21];
        out_rdy = r[20];
        din_vld = r[19];
        din_sop = r[18];
        din_eop = r[17];
        din_mty = r[16];
        din     = r[15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] observed();
        return {ovf_err, b_rdy, dout_vld, dout_sop, dout_eop, dout};
    endfunction

    task automatic test_reset();
        logic [12:0] got;
        apply(mk(0, 1, 1, 1, 1, 0, 16'hDEAD));
        tick();
        tick();
        got = observed();
        total++;
        if (got !== ex(0, 1, 0, 0, 0, 8'h00)) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", got, ex(0, 1, 0, 0, 0, 8'h00));
        end
        apply(mk(1, 1, 0, 0, 0, 0, 16'h0000));
    endtask

    task automatic test_even();
        logic [21:0] vi [5];
        logic [12:0] ve [5];
        logic [12:0] got;
        vi[0] = mk(1, 1, 1, 1, 0, 0, 16'h2211); ve[0] = ex(0, 0, 1, 1, 0, 8'h11);
        vi[1] = mk(1, 1, 1, 0, 1, 0, 16'h4433); ve[1] = ex(0, 0, 1, 0, 0, 8'h22);
        vi[2] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[2] = ex(0, 0, 1, 0, 0, 8'h33);
        vi[3] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[3] = ex(0, 1, 1, 0, 1, 8'h44);
        vi[4] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[4] = ex(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL even[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_odd();
        logic [21:0] vi [4];
        logic [12:0] ve [4];
        logic [12:0] got;
        vi[0] = mk(1, 1, 1, 1, 0, 0, 16'h2211); ve[0] = ex(0, 0, 1, 1, 0, 8'h11);
        vi[1] = mk(1, 1, 1, 0, 1, 1, 16'hAB00); ve[1] = ex(0, 0, 1, 0, 0, 8'h22);
        vi[2] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[2] = ex(0, 1, 1, 0, 1, 8'hAB);
        vi[3] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[3] = ex(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL odd[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [21:0] vi [2];
        logic [12:0] ve [2];
        logic [12:0] got;
        vi[0] = mk(1, 1, 1, 1, 1, 1, 16'h5A77); ve[0] = ex(0, 1, 1, 1, 1, 8'h5A);
        vi[1] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[1] = ex(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL single[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] vi [10];
        logic [12:0] ve [10];
        logic [12:0] got;
        vi[0] = mk(1, 1, 1, 1, 0, 0, 16'h2211); ve[0] = ex(0, 0, 1, 1, 0, 8'h11);
        vi[1] = mk(1, 0, 1, 0, 1, 0, 16'h4433); ve[1] = ex(0, 0, 1, 1, 0, 8'h11);
        for (int i = 2; i < 6; i++) begin
            vi[i] = mk(1, 0, 0, 0, 0, 0, 16'h0000);
            ve[i] = ex(0, 0, 1, 1, 0, 8'h11);
        end
        vi[6] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[6] = ex(0, 0, 1, 0, 0, 8'h22);
        vi[7] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[7] = ex(0, 0, 1, 0, 0, 8'h33);
        vi[8] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[8] = ex(0, 1, 1, 0, 1, 8'h44);
        vi[9] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[9] = ex(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL backpressure[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] vi [5];
        logic [12:0] ve [5];
        logic [12:0] got;
        vi[0] = mk(1, 1, 1, 1, 1, 0, 16'h6655); ve[0] = ex(0, 0, 1, 1, 0, 8'h55);
        vi[1] = mk(1, 1, 1, 1, 1, 0, 16'h8877); ve[1] = ex(0, 0, 1, 0, 1, 8'h66);
        vi[2] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[2] = ex(0, 0, 1, 1, 0, 8'h77);
        vi[3] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[3] = ex(0, 1, 1, 0, 1, 8'h88);
        vi[4] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[4] = ex(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [21:0] vi [7];
        logic [12:0] ve [7];
        logic [12:0] got;
        vi[0] = mk(1, 0, 1, 1, 0, 0, 16'hB2B1); ve[0] = ex(0, 0, 1, 1, 0, 8'hB1);
        vi[1] = mk(1, 0, 1, 0, 1, 0, 16'hB4B3); ve[1] = ex(0, 0, 1, 1, 0, 8'hB1);
        vi[2] = mk(1, 0, 1, 1, 1, 0, 16'hC2C1); ve[2] = ex(1, 0, 1, 1, 0, 8'hB1);
        vi[3] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[3] = ex(1, 0, 1, 0, 0, 8'hB2);
        vi[4] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[4] = ex(1, 0, 1, 0, 0, 8'hB3);
        vi[5] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[5] = ex(1, 1, 1, 0, 1, 8'hB4);
        vi[6] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[6] = ex(1, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL overflow[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [21:0] vi [6];
        logic [12:0] ve [6];
        logic [12:0] got;
        vi[0] = mk(1, 1, 1, 1, 0, 0, 16'h0201); ve[0] = ex(1, 0, 1, 1, 0, 8'h01);
        vi[1] = mk(0, 1, 1, 0, 0, 0, 16'h0403); ve[1] = ex(0, 1, 0, 0, 0, 8'h00);
        vi[2] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[2] = ex(0, 1, 0, 0, 0, 8'h00);
        vi[3] = mk(1, 1, 1, 1, 1, 0, 16'h6655); ve[3] = ex(0, 0, 1, 1, 0, 8'h55);
        vi[4] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[4] = ex(0, 1, 1, 0, 1, 8'h66);
        vi[5] = mk(1, 1, 0, 0, 0, 0, 16'h0000); ve[5] = ex(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            apply(vi[i]);
            tick();
            got = observed();
            total++;
            if (got !== ve[i]) begin
                bad++;
                $display("FAIL rst_mid[%0d] got=%h exp=%h", i, got, ve[i]);
            end
        end
    endtask

    initial begin
        apply(mk(0, 1, 0, 0, 0, 0, 16'h0000));
        test_reset();
        test_even();
        test_odd();
        test_single_byte();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
